// File: rtl/ads_frame_reader_pkg.sv
// ---------------------------------------------------------------------------
// ads_pkg : shared widths, FSM state type and sign-extension helper for the
//           ADS129x frame reader.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ads_pkg;

  localparam int STATUS_BITS = 24;
  localparam int SAMPLE_BITS = 24;
  localparam int OUT_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } ads_rd_state_t;

  function automatic logic [OUT_W-1:0] sext24(input logic [SAMPLE_BITS-1:0] s);
    return {{(OUT_W-SAMPLE_BITS){s[SAMPLE_BITS-1]}}, s};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ads_sample_fifo.sv
// ---------------------------------------------------------------------------
// ads_sample_fifo : first-word-fall-through FIFO with a free-slot count.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ads_sample_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_push;
  logic             w_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_valid   = (w_count != '0);
  assign o_free    = c_DEPTH - w_count;
  assign w_pop     = i_rd_en && o_valid;
  assign w_push    = i_wr_en && ((w_count != c_DEPTH) || w_pop);
  // Output forced to zero when empty so the stream port idles at all-zero.
  assign o_rd_data = o_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ads_frame_reader.sv
// ---------------------------------------------------------------------------
// ads_frame_reader : RDATAC frame capture from an ADS129x into an
//                    AXI4-Stream FIFO with frame-atomic drop accounting.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ads_frame_reader
  import ads_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 32,
  parameter int CS_HOLD    = 4
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              enable,
  input  logic              drdy_n,
  input  logic              spi_miso,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  output logic [OUT_W-1:0]  m_tdata,
  output logic [3:0]        m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [15:0]       drop_cnt,
  output logic [31:0]       frame_cnt,
  output logic              busy
);

  localparam int FIFO_W     = OUT_W + 4 + 1;
  localparam int FREE_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int TOTAL_BITS = STATUS_BITS + SAMPLE_BITS * N_CH;
  localparam int BIT_W      = $clog2(TOTAL_BITS + 1);
  localparam int CNT_W      = 16;

  localparam logic [CNT_W-1:0]  c_DIV_LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  c_HOLD_LAST   = CNT_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0]  c_BITS_TOTAL  = BIT_W'(TOTAL_BITS);
  localparam logic [4:0]        c_WBIT_LAST   = 5'(SAMPLE_BITS - 1);
  localparam logic [FREE_W-1:0] c_FRAME_WORDS = FREE_W'(N_CH + 1);
  localparam logic [3:0]        c_LAST_IDX    = 4'(N_CH);

  ads_rd_state_t r_state, w_state_nxt;

  logic r_drdy_s1, r_drdy_s2, r_drdy_s3;
  logic [CNT_W-1:0]       r_div;
  logic                   r_phase;
  logic                   r_sclk;
  logic [BIT_W-1:0]       r_bit;
  logic [4:0]             r_wbit;
  logic [3:0]             r_widx;
  logic [SAMPLE_BITS-1:0] r_shift;
  logic                   r_word_done;
  logic                   r_wr_en;
  logic [FIFO_W-1:0]      r_wr_data;
  logic [15:0]            r_drop_cnt;
  logic [31:0]            r_frame_cnt;

  logic              w_drdy_fall, w_fits, w_tick, w_start, w_drop;
  logic              w_setup_done, w_shift_done, w_hold_done;
  logic              w_cs_n, w_busy;
  logic [FREE_W-1:0] w_free;
  logic [FIFO_W-1:0] w_fifo_dout;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_drdy_s1 <= 1'b1;
      r_drdy_s2 <= 1'b1;
      r_drdy_s3 <= 1'b1;
    end else begin
      r_drdy_s1 <= drdy_n;
      r_drdy_s2 <= r_drdy_s1;
      r_drdy_s3 <= r_drdy_s2;
    end
  end

  assign w_drdy_fall  = r_drdy_s3 & ~r_drdy_s2;
  assign w_fits       = (w_free >= c_FRAME_WORDS);
  assign w_tick       = (r_div == c_DIV_LAST);
  assign w_start      = (r_state == IDLE) && w_drdy_fall && enable && w_fits;
  assign w_setup_done = (r_state == SETUP) && w_tick;
  assign w_shift_done = (r_state == SHIFT) && w_tick && r_phase && (r_bit == c_BITS_TOTAL);
  assign w_hold_done  = (r_state == HOLD) && (r_div == c_HOLD_LAST);
  // Any DRDY while a frame is in flight is an overrun; in IDLE only a lack of space drops.
  assign w_drop       = w_drdy_fall && ((r_state == IDLE) ? (enable && !w_fits) : 1'b1);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_start)      w_state_nxt = SETUP;
      SETUP: if (w_setup_done) w_state_nxt = SHIFT;
      SHIFT: if (w_shift_done) w_state_nxt = HOLD;
      HOLD:  if (w_hold_done)  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cs_n = 1'b1;
    w_busy = 1'b0;
    if (r_state != IDLE) begin
      w_cs_n = 1'b0;
      w_busy = 1'b1;
    end
  end

  // SCLK phase 0 is the high half of a bit period, phase 1 the low half.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_div       <= '0;
      r_phase     <= 1'b0;
      r_sclk      <= 1'b0;
      r_bit       <= '0;
      r_wbit      <= '0;
      r_widx      <= '0;
      r_shift     <= '0;
      r_word_done <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
    end else begin
      r_word_done <= 1'b0;
      r_wr_en     <= r_word_done;
      if (r_word_done) begin
        r_wr_data <= {(r_widx == c_LAST_IDX), r_widx,
                      (r_widx == 4'd0) ? {{(OUT_W-STATUS_BITS){1'b0}}, r_shift}
                                       : sext24(r_shift)};
        r_widx    <= r_widx + 4'd1;
      end
      unique case (r_state)
        IDLE: begin
          r_div   <= '0;
          r_phase <= 1'b0;
          r_sclk  <= 1'b0;
          r_bit   <= '0;
          r_wbit  <= '0;
          r_widx  <= '0;
        end
        SETUP: begin
          if (w_tick) begin
            r_div  <= '0;
            r_sclk <= 1'b1;
          end else begin
            r_div <= r_div + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (!w_tick) begin
            r_div <= r_div + CNT_W'(1);
          end else begin
            r_div   <= '0;
            r_phase <= ~r_phase;
            if (!r_phase) begin
              r_sclk  <= 1'b0;
              r_shift <= {r_shift[SAMPLE_BITS-2:0], spi_miso};
              r_bit   <= r_bit + BIT_W'(1);
              if (r_wbit == c_WBIT_LAST) begin
                r_wbit      <= '0;
                r_word_done <= 1'b1;
              end else begin
                r_wbit <= r_wbit + 5'd1;
              end
            end else begin
              r_sclk <= !w_shift_done;
            end
          end
        end
        HOLD: begin
          r_sclk <= 1'b0;
          if (w_hold_done) r_div <= '0;
          else             r_div <= r_div + CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_drop_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_hold_done) r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  ads_sample_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .i_wr_en   (r_wr_en),
    .i_wr_data (r_wr_data),
    .i_rd_en   (m_tready),
    .o_rd_data (w_fifo_dout),
    .o_valid   (m_tvalid),
    .o_free    (w_free)
  );

  assign {m_tlast, m_tuser, m_tdata} = w_fifo_dout;
  assign spi_sclk  = r_sclk;
  assign spi_cs_n  = w_cs_n;
  assign spi_mosi  = 1'b0;
  assign busy      = w_busy;
  assign drop_cnt  = r_drop_cnt;
  assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: doc/ads_frame_reader.md
# ads_frame_reader

Parametrised capture engine for the ADS129x EMG front end, running in continuous-read (RDATAC) mode. On each DRDY falling edge it clocks out one full frame over SPI: a 24-bit status word plus N_CH 24-bit samples. Each word is widened to 32 bits and written into an internal FIFO, which is drained through an AXI4-Stream-style master port. The block sits between the ADC pins and the acquisition DMA/AXI-Lite control path, and adds frame-atomic buffering and drop accounting.

## Interface
Parameters:
- N_CH, 8: channels per frame, 1..8.
- CLK_DIV, 4: SCLK half-period in ACLK cycles, ≥2; SCLK = ACLK/(2·CLK_DIV).
- FIFO_DEPTH, 32: words; power of 2, ≥ N_CH+1.
- CS_HOLD, 4: ACLK cycles cs_n stays low after the last SCLK edge.

Ports:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset; one clock, async active-low reset, no other clock domains.
- enable  in  1  arms frame capture.
- drdy_n  in  1  ADC data-ready, asynchronous to ACLK.
- spi_miso  in  1  ADC DOUT.
- spi_sclk  out  1  SPI clock, CPOL=0.
- spi_cs_n  out  1  chip select.
- spi_mosi  out  1  tied 0 (no command during RDATAC).
- m_tdata  out  32  status (zero-extended) or sample (sign-extended).
- m_tuser  out  4  word index: 0 = status, 1..N_CH = channel.
- m_tlast  out  1  high on word N_CH.
- m_tvalid  out  1  FIFO not empty.
- m_tready  in  1  consumer accepts.
- drop_cnt  out  16  frames dropped, saturating.
- frame_cnt  out  32  frames captured, wraps.
- busy  out  1  state ≠ IDLE.

## Operation
- drdy_n passes through a 2-FF synchroniser, then a falling-edge detector produces drdy_fall.
- FSM states: IDLE → SETUP → SHIFT → HOLD → IDLE.
- IDLE: on drdy_fall with enable=1:
  - If FIFO free ≥ N_CH+1: go to SETUP and assert cs_n low.
  - Otherwise: stay in IDLE, drop_cnt++ (saturating at 0xFFFF), and no SCLK toggles.
  - drdy_fall with enable=0 is ignored and not counted.
- SETUP: lasts CLK_DIV cycles, then go to SHIFT.
- SHIFT: clocks out 24·(N_CH+1) SCLK pulses, SPI mode 1.
  - SCLK rises at the start of each period; MISO is sampled on the falling edge; MSB first.
  - After every 24th bit, the assembled word is pushed the next cycle with its index.
  - Status word {8'h00, s[23:0]}; samples {{8{s[23]}}, s[23:0]}.
- HOLD: lasts CS_HOLD cycles with SCLK=0, then cs_n goes high, frame_cnt++, and the FSM returns to IDLE.
- drdy_fall in SETUP/SHIFT/HOLD: drop_cnt++ (overrun); the frame in progress is unaffected.
- enable deasserted mid-frame: the current frame completes.
- Frames are atomic: space is reserved at frame start, so no word is ever lost or partial. A pop simultaneous with a push is always legal.
- FIFO is first-word-fall-through. m_tdata/m_tuser/m_tlast are stable while m_tvalid=1 and m_tready=0.

## Timing
- Reset values:
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0.
  - m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0.
  - drop_cnt=0, frame_cnt=0, busy=0.
  - FSM=IDLE, FIFO empty.
- drdy_n falling edge → cs_n low: 3 ACLK cycles (2 sync + 1 detect).
- cs_n low → first SCLK rise: CLK_DIV cycles.
- Frame duration, cs_n low to cs_n high: CLK_DIV + 48·CLK_DIV·(N_CH+1) + CS_HOLD cycles.
- Last bit of a word sampled → m_tvalid (FIFO previously empty): 2 cycles.
- Reset asserted mid-frame: all outputs return to reset values asynchronously, and FIFO contents are discarded.
- After ARESETN deasserts, the first drdy_fall is honoured no earlier than 3 cycles later.

## Structure
- Package ads_pkg holds:
  - STATUS_BITS=24, SAMPLE_BITS=24, OUT_W=32;
  - enum ads_rd_state_t {IDLE, SETUP, SHIFT, HOLD};
  - function sext24 (sign-extend 24→32).
- Sub-module ads_sample_fifo: synchronous FWFT FIFO, width 32+4+1, depth FIFO_DEPTH; exposes a free-count output.
- Top level contains the synchroniser, SCLK divider/bit counter, FSM, shift register and counters.

## Test plan
- N_CH=8, CLK_DIV=4, m_tready=1; ADC model returns status 0xC00000 and ch1..8 = 0x7FFFFF, 0x800000, 0x000001, …:
  - 9 words out, tuser 0..8, tlast on word 8;
  - word0=0x00C00000, ch1=0x007FFFFF, ch2=0xFF800000;
  - cs_n low for exactly 4+1728+4 cycles.
- m_tready=0, FIFO_DEPTH=32, 4 DRDY pulses: frames 1–3 stored (27 words); frame 4 dropped with no SCLK activity; drop_cnt=1, frame_cnt=3.
- DRDY pulse mid-SHIFT: current frame intact, drop_cnt=1, no extra frame.
- enable=0, DRDY pulses: no cs_n activity, counters stay 0.
- ARESETN low during SHIFT: cs_n=1 and sclk=0 immediately, m_tvalid=0; next DRDY after release yields a clean frame.
- Backpressure: random m_tready at 30%, 100 frames: stream equals the model sequence, no duplicates or gaps.
